// File: rtl/serial_frame_ctrl.sv
// Frame sequencer for the 40-bit parallel-to-serial select mux: latches a word,
// walks the mux select index at a programmable bit rate and registers the line.
module serial_frame_ctrl #(
    parameter int   WORD_W   = 40,
    parameter int   IDX_W    = 6,
    parameter int   DIV_W    = 16,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] data_in,
    input  logic [IDX_W-1:0]  len,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  div,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic              abort,
    output logic [WORD_W-1:0] mux_data,
    output logic [IDX_W-1:0]  mux_sel,
    input  logic              mux_bit,
    output logic              ser_out,
    output logic              bit_strobe,
    output logic              tx_active,
    output logic              done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [IDX_W-1:0] MAX_LEN = IDX_W'(WORD_W);

    state_t            state_q;
    logic [WORD_W-1:0] data_q;
    logic [IDX_W-1:0]  len_q;
    logic [DIV_W-1:0]  div_q;
    logic              dir_q;
    logic [IDX_W-1:0]  sel_q;
    logic [IDX_W-1:0]  bit_cnt_q;
    logic [DIV_W-1:0]  div_cnt_q;
    logic              ser_q;
    logic              strobe_q;
    logic              tx_q;
    logic              last_q;
    logic              done_q;

    logic [IDX_W-1:0]  len_d;
    logic [IDX_W-1:0]  sel_first_d;
    logic [IDX_W-1:0]  sel_step_d;
    logic              bit_end;
    logic              last_bit;

    always_comb begin
        len_d = len;
        if (len == '0 || len > MAX_LEN) begin
            len_d = MAX_LEN;
        end
        sel_first_d = msb_first ? (len_d - IDX_W'(1)) : '0;
        sel_step_d  = dir_q ? (sel_q - IDX_W'(1)) : (sel_q + IDX_W'(1));
        bit_end     = (state_q == SHIFT) && (div_cnt_q == div_q);
        last_bit    = bit_end && (bit_cnt_q == len_q - IDX_W'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            len_q     <= '0;
            div_q     <= '0;
            dir_q     <= 1'b0;
            sel_q     <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            ser_q     <= IDLE_LVL;
            strobe_q  <= 1'b0;
            tx_q      <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // Line stage: ser_out follows the select index by one clock
            ser_q    <= (state_q == SHIFT) ? mux_bit : IDLE_LVL;
            tx_q     <= (state_q == SHIFT);
            strobe_q <= (state_q == SHIFT) && (div_cnt_q == '0);
            // done is delayed once more so it lands on the first idle line clock
            last_q   <= last_bit && !abort;
            done_q   <= last_q;

            case (state_q)
                IDLE: begin
                    sel_q <= '0;
                    if (data_valid) begin
                        data_q    <= data_in;
                        len_q     <= len_d;
                        div_q     <= div;
                        dir_q     <= msb_first;
                        sel_q     <= sel_first_d;
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        sel_q     <= '0;
                        bit_cnt_q <= '0;
                        div_cnt_q <= '0;
                    end else if (bit_end) begin
                        div_cnt_q <= '0;
                        if (last_bit) begin
                            state_q   <= IDLE;
                            sel_q     <= '0;
                            bit_cnt_q <= '0;
                        end else begin
                            sel_q     <= sel_step_d;
                            bit_cnt_q <= bit_cnt_q + IDX_W'(1);
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_ready = (state_q == IDLE);
    assign mux_data   = data_q;
    assign mux_sel    = sel_q;
    assign ser_out    = ser_q;
    assign bit_strobe = strobe_q;
    assign tx_active  = tx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Directed bench for serial_frame_ctrl; a behavioural 40:1 mux closes the loop.
module tb_serial_frame_ctrl;

    logic        clk;
    logic        rst;
    logic [39:0] data_in;
    logic [5:0]  len;
    logic        msb_first;
    logic [15:0] div;
    logic        data_valid;
    logic        data_ready;
    logic        abort;
    logic [39:0] mux_data;
    logic [5:0]  mux_sel;
    logic        mux_bit;
    logic        ser_out;
    logic        bit_strobe;
    logic        tx_active;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent run_frame
    logic [63:0] cap;
    int          n_strobe, tx_cycles, first_strobe_n, ready_n, done_n, hold_err;
    logic [5:0]  first_sel, max_sel;

    serial_frame_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .len        (len),
        .msb_first  (msb_first),
        .div        (div),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .abort      (abort),
        .mux_data   (mux_data),
        .mux_sel    (mux_sel),
        .mux_bit    (mux_bit),
        .ser_out    (ser_out),
        .bit_strobe (bit_strobe),
        .tx_active  (tx_active),
        .done       (done)
    );

    assign mux_bit = (mux_sel < 6'd40) ? mux_data[mux_sel] : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Accept one frame, then scramble the inputs and record the line until done.
    task automatic run_frame(input logic [39:0] d, input logic [5:0] l, input logic m,
                             input logic [15:0] dv);
        logic cur;
        cap = '0; n_strobe = 0; tx_cycles = 0; first_strobe_n = -1;
        ready_n = -1; done_n = -1; hold_err = 0; cur = 1'b1;
        data_in = d; len = l; msb_first = m; div = dv; data_valid = 1'b1;
        check("accept_ready", 64'(data_ready), 64'd1);
        @(posedge clk); #1;
        data_valid = 1'b0; abort = 1'b0;
        data_in = ~d; len = 6'd3; msb_first = ~m; div = 16'd5;
        first_sel = mux_sel; max_sel = mux_sel;
        for (int n = 1; n <= 2000; n++) begin
            @(posedge clk); #1;
            if (bit_strobe) begin
                if (first_strobe_n < 0) first_strobe_n = n;
                cap[n_strobe] = ser_out;
                cur = ser_out;
                n_strobe++;
            end else if (tx_active && ser_out !== cur) begin
                hold_err++;
            end
            if (tx_active) tx_cycles++;
            if (mux_sel > max_sel) max_sel = mux_sel;
            if (data_ready && ready_n < 0) ready_n = n;
            if (done) begin
                done_n = n;
                break;
            end
        end
    endtask

    initial begin
        int gap, dcnt, rises, strobes;
        logic prev_tx, gap_lvl;

        rst = 1'b0; data_in = '0; len = '0; msb_first = 1'b0; div = '0;
        data_valid = 1'b0; abort = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_ready",  64'(data_ready), 64'd1);
        check("rst_ser",    64'(ser_out),    64'd1);
        check("rst_sel",    64'(mux_sel),    64'd0);
        check("rst_data",   64'(mux_data),   64'd0);
        check("rst_tx",     64'(tx_active),  64'd0);
        check("rst_strobe", 64'(bit_strobe), 64'd0);
        check("rst_done",   64'(done),       64'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // 0xA5, 8 bits LSB first, one clock per bit
        run_frame(40'h00_0000_00A5, 6'd8, 1'b0, 16'd0);
        check("f1_bits",    cap,                 64'hA5);
        check("f1_sel0",    64'(first_sel),      64'd0);
        check("f1_strobes", 64'(n_strobe),       64'd8);
        check("f1_tx",      64'(tx_cycles),      64'd8);
        check("f1_first",   64'(first_strobe_n), 64'd1);
        check("f1_ready",   64'(ready_n),        64'd8);
        check("f1_done",    64'(done_n),         64'd9);
        check("f1_ser_end", 64'(ser_out),        64'd1);
        check("f1_sel_end", 64'(mux_sel),        64'd0);

        // Same word MSB first, four clocks per bit
        run_frame(40'h00_0000_00A5, 6'd8, 1'b1, 16'd3);
        check("f2_bits",    cap,            64'hA5);
        check("f2_sel0",    64'(first_sel), 64'd7);
        check("f2_strobes", 64'(n_strobe),  64'd8);
        check("f2_tx",      64'(tx_cycles), 64'd32);
        check("f2_hold",    64'(hold_err),  64'd0);
        check("f2_ready",   64'(ready_n),   64'd32);
        check("f2_done",    64'(done_n),    64'd33);

        // Non-symmetric word exposes the direction: 0x0F MSB first -> 0,0,0,0,1,1,1,1
        run_frame(40'h00_0000_000F, 6'd8, 1'b1, 16'd0);
        check("f3_bits", cap,            64'hF0);
        check("f3_sel0", 64'(first_sel), 64'd7);

        // len=0 and len=45 both clamp to 40
        run_frame(40'h80_0000_0001, 6'd0, 1'b0, 16'd0);
        check("l0_bits",    cap,           64'h80_0000_0001);
        check("l0_strobes", 64'(n_strobe), 64'd40);
        check("l0_maxsel",  64'(max_sel),  64'd39);
        check("l0_done",    64'(done_n),   64'd41);
        run_frame(40'h80_0000_0001, 6'd45, 1'b0, 16'd0);
        check("l45_bits",    cap,           64'h80_0000_0001);
        check("l45_strobes", 64'(n_strobe), 64'd40);
        check("l45_maxsel",  64'(max_sel),  64'd39);

        // Back-to-back with data_valid held high: len=4, div=1
        data_in = 40'h6; len = 6'd4; msb_first = 1'b0; div = 16'd1; data_valid = 1'b1;
        @(posedge clk); #1;
        gap = 0; dcnt = 0; rises = 0; strobes = 0; prev_tx = 1'b0; gap_lvl = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            if (tx_active && !prev_tx) rises++;
            if (n >= 2 && n <= 16 && !tx_active) begin
                gap++;
                gap_lvl = gap_lvl & ser_out;
            end
            if (done) dcnt++;
            if (bit_strobe) strobes++;
            prev_tx = tx_active;
            if (n == 9) data_valid = 1'b0;
        end
        check("b2b_gap",     64'(gap),     64'd1);
        check("b2b_gaplvl",  64'(gap_lvl), 64'd1);
        check("b2b_frames",  64'(rises),   64'd2);
        check("b2b_done",    64'(dcnt),    64'd2);
        check("b2b_strobes", 64'(strobes), 64'd8);

        // Abort during bit 5 of a 40-bit all-zero frame
        data_in = 40'h0; len = 6'd40; msb_first = 1'b0; div = 16'd0; data_valid = 1'b1;
        @(posedge clk); #1 data_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        dcnt = done ? 1 : 0;
        check("abrt_ready", 64'(data_ready), 64'd1);
        check("abrt_sel",   64'(mux_sel),    64'd0);
        @(posedge clk); #1;
        check("abrt_ser", 64'(ser_out),   64'd1);
        check("abrt_tx",  64'(tx_active), 64'd0);
        if (done) dcnt++;
        repeat (10) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("abrt_nodone", 64'(dcnt), 64'd0);

        // abort together with data_valid in IDLE: frame is still accepted
        abort = 1'b1;
        run_frame(40'h00_0000_0036, 6'd6, 1'b0, 16'd0);
        check("post_abrt_bits", cap,         64'h36);
        check("post_abrt_done", 64'(done_n), 64'd7);

        // Asynchronous reset in the middle of bit 20
        data_in = 40'h12_3456_7800; len = 6'd40; msb_first = 1'b0; div = 16'd0;
        data_valid = 1'b1;
        @(posedge clk); #1 data_valid = 1'b0;
        repeat (20) begin @(posedge clk); #1; end
        check("pre_rst_sel", 64'(mux_sel), 64'd20);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ser",   64'(ser_out),    64'd1);
        check("mid_rst_tx",    64'(tx_active),  64'd0);
        check("mid_rst_ready", 64'(data_ready), 64'd1);
        check("mid_rst_sel",   64'(mux_sel),    64'd0);
        check("mid_rst_data",  64'(mux_data),   64'd0);
        check("mid_rst_strb",  64'(bit_strobe), 64'd0);
        #1 rst = 1'b0;
        dcnt = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done) dcnt++;
        end
        check("mid_rst_nodone", 64'(dcnt), 64'd0);
        run_frame(40'h00_0000_000F, 6'd8, 1'b1, 16'd0);
        check("post_rst_bits", cap,         64'hF0);
        check("post_rst_done", 64'(done_n), 64'd9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
